// File: rtl/decode.sv
// decode: RV32I decode stage registering one micro-op per cycle; DECODE_ILLEGAL_DETECT_EN enables illegal-encoding detection
module decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [4:0]  reg_raddr1_o,
  output logic [4:0]  reg_raddr2_o,
  input  logic [31:0] reg_rdata1_i,
  input  logic [31:0] reg_rdata2_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_sub_o,
  output logic        alu_arith_o,
  output logic        branch_o,
  output logic [2:0]  branch_cond_o,
  output logic        jump_o,
  output logic        jalr_o,
  output logic        load_o,
  output logic        store_o,
  output logic [2:0]  ls_funct3_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_waddr_o,
  output logic        illegal_o
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc, op1, op2, rs1, rs2, imm;
    logic [2:0]  alu_op;
    logic        sub, arith, branch;
    logic [2:0]  cond;
    logic        jump, jalr, load, store;
    logic [2:0]  ls;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
  } uop_t;

  uop_t        d, q;
  logic        valid_q, ill;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1d, rs2d, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign rd = instr_i[11:7];
  assign reg_raddr1_o = instr_i[19:15];
  assign reg_raddr2_o = instr_i[24:20];
  assign rs1d = |reg_raddr1_o ? reg_rdata1_i : '0;
  assign rs2d = |reg_raddr2_o ? reg_rdata2_i : '0;
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign input_ready_o = !valid_q | output_ready_i;

`ifdef DECODE_ILLEGAL_DETECT_EN
  // flag encodings outside RV32I, including compressed/non-32-bit words
  always_comb begin
    case (opc)
      OP_R:            ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
      OP_I:            ill = (f3 == 3'd1 && f7 != 7'b0) || (f3 == 3'd5 && f7 != 7'b0 && f7 != 7'b0100000);
      LOAD:            ill = f3 == 3'd3 || f3 > 3'd5;
      STORE:           ill = f3 > 3'd2;
      BRANCH:          ill = f3 == 3'd2 || f3 == 3'd3;
      JALR:            ill = f3 != 3'd0;
      JAL, LUI, AUIPC: ill = 1'b0;
      FENCE:           ill = f3 > 3'd1;
      SYSTEM:          ill = instr_i[31:7] != 25'h0 && instr_i[31:7] != 25'h2000;
      default:         ill = 1'b1;
    endcase
  end
`else
  assign ill = 1'b0;
`endif

  // combinational decode; fence, system and unknown opcodes leave the op as a NOP
  always_comb begin
    d = '0;
    d.pc = pc_i;
    d.rs1 = rs1d;
    d.rs2 = rs2d;
    case (opc)
      OP_R:   begin d.op1 = rs1d; d.op2 = rs2d; d.alu_op = f3; d.sub = f7[5] & (f3 == 3'd0); d.arith = f7[5] & (f3 == 3'd5); d.we = 1'b1; end
      OP_I:   begin d.imm = imm_i; d.op1 = rs1d; d.op2 = imm_i; d.alu_op = f3; d.arith = f7[5] & (f3 == 3'd5); d.we = 1'b1; end
      LOAD:   begin d.imm = imm_i; d.op1 = rs1d; d.op2 = imm_i; d.load = 1'b1; d.ls = f3; d.we = 1'b1; end
      STORE:  begin d.imm = imm_s; d.op1 = rs1d; d.op2 = imm_s; d.store = 1'b1; d.ls = f3; end
      BRANCH: begin d.imm = imm_b; d.op1 = rs1d; d.op2 = rs2d; d.branch = 1'b1; d.cond = f3; end
      JAL:    begin d.imm = imm_j; d.op1 = pc_i; d.op2 = 32'd4; d.jump = 1'b1; d.we = 1'b1; end
      JALR:   begin d.imm = imm_i; d.op1 = pc_i; d.op2 = 32'd4; d.jump = 1'b1; d.jalr = 1'b1; d.we = 1'b1; end
      LUI:    begin d.imm = imm_u; d.op2 = imm_u; d.we = 1'b1; end
      AUIPC:  begin d.imm = imm_u; d.op1 = pc_i; d.op2 = imm_u; d.we = 1'b1; end
      default: ;
    endcase
    d.we = d.we & (|rd);
    d.rd = d.we ? rd : 5'd0;
    if (ill) begin
      d = '0;
      d.pc = pc_i;
      d.ill = 1'b1;
    end
  end

  // micro-op register: reset beats flush, flush beats accept, stall holds everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (input_ready_o) begin
      valid_q <= input_valid_i;
      if (input_valid_i) q <= d;
    end
  end

  assign output_valid_o = valid_q;
  assign pc_o = q.pc;
  assign op1_o = q.op1;
  assign op2_o = q.op2;
  assign rs1_data_o = q.rs1;
  assign rs2_data_o = q.rs2;
  assign imm_o = q.imm;
  assign alu_op_o = q.alu_op;
  assign alu_sub_o = q.sub;
  assign alu_arith_o = q.arith;
  assign branch_o = q.branch;
  assign branch_cond_o = q.cond;
  assign jump_o = q.jump;
  assign jalr_o = q.jalr;
  assign load_o = q.load;
  assign store_o = q.store;
  assign ls_funct3_o = q.ls;
  assign reg_write_o = q.we;
  assign reg_waddr_o = q.rd;
  assign illegal_o = q.ill;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed self-checking bench for the decode stage
module tb_decode;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = 32'h00000013, pc = '0;
  logic        in_ready, out_valid, alu_sub, alu_arith, branch, jump, jalr, load, store, reg_write, illegal;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] rdata1, rdata2, pc_out, op1, op2, rs1_data, rs2_data, imm;
  logic [2:0]  alu_op, bcond, ls_f3;
  logic [31:0] rf [32];
  int          checks = 0, errors = 0;
`ifdef DECODE_ILLEGAL_DETECT_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  decode dut (
    .clk_i(clk), .rst_i(rst), .input_valid_i(in_valid), .input_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush),
    .reg_raddr1_o(raddr1), .reg_raddr2_o(raddr2), .reg_rdata1_i(rdata1), .reg_rdata2_i(rdata2),
    .output_valid_o(out_valid), .output_ready_i(out_ready), .pc_o(pc_out),
    .op1_o(op1), .op2_o(op2), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .imm_o(imm),
    .alu_op_o(alu_op), .alu_sub_o(alu_sub), .alu_arith_o(alu_arith),
    .branch_o(branch), .branch_cond_o(bcond), .jump_o(jump), .jalr_o(jalr),
    .load_o(load), .store_o(store), .ls_funct3_o(ls_f3),
    .reg_write_o(reg_write), .reg_waddr_o(waddr), .illegal_o(illegal)
  );

  always #5 clk = ~clk;
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic v);
    instr = i;
    pc = p;
    in_valid = v;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEADBEEF;
    rf[1] = 32'd7;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", {alu_op, alu_sub, alu_arith, branch, jump, jalr, load, store, reg_write, waddr, illegal}, 0);
    chk("rst_data", pc_out | op1 | op2 | imm | rs1_data | rs2_data, 0);
    rst = 1'b0;
    drive(32'hFFF08293, 32'h100, 1);
    chk("addi_raddr1", raddr1, 1);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_op1", op1, 7);
    chk("addi_op2", op2, 32'hFFFFFFFF);
    chk("addi_waddr", {reg_write, waddr}, {1'b1, 5'd5});
    chk("addi_pc", pc_out, 32'h100);
    drive(32'h008000EF, 32'h1000, 1);
    tick();
    chk("jal_ops", {op1, op2}, {32'h1000, 32'd4});
    chk("jal_imm", imm, 8);
    chk("jal_ctrl", {jump, jalr, reg_write, waddr}, {1'b1, 1'b0, 1'b1, 5'd1});
    drive(32'h402081B3, 32'h1004, 1);
    tick();
    chk("sub_ops", {op1, op2}, {32'd7, 32'h102});
    chk("sub_ctrl", {alu_op, alu_sub, alu_arith, waddr}, {3'd0, 1'b1, 1'b0, 5'd3});
    drive(32'h40315213, 32'h1008, 1);
    tick();
    chk("srai_op2", op2, 32'h403);
    chk("srai_ctrl", {alu_op, alu_sub, alu_arith, reg_write, waddr}, {3'd5, 1'b0, 1'b1, 1'b1, 5'd4});
    drive(32'h00202623, 32'h100C, 1);
    tick();
    chk("sw_ops", {op1, op2}, {32'd0, 32'd12});
    chk("sw_x0", rs1_data, 0);
    chk("sw_rs2", rs2_data, 32'h102);
    chk("sw_ctrl", {store, load, ls_f3, reg_write, alu_op}, {1'b1, 1'b0, 3'd2, 1'b0, 3'd0});
    drive(32'hFE208EE3, 32'h1010, 1);
    tick();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_ctrl", {branch, bcond, reg_write, op2}, {1'b1, 3'd0, 1'b0, 32'h102});
    drive(32'h123453B7, 32'h1014, 1);
    tick();
    chk("lui_ops", {op1, op2}, {32'd0, 32'h12345000});
    chk("lui_wr", {reg_write, waddr}, {1'b1, 5'd7});
    drive(32'h00001017, 32'h2000, 1);
    tick();
    chk("auipc_ops", {op1, op2}, {32'h2000, 32'h1000});
    chk("auipc_rd0", {reg_write, waddr}, 0);
    drive(32'h00000073, 32'h2004, 1);
    tick();
    chk("ecall_nop", {reg_write, load, store, branch, jump, illegal}, 0);
    drive(32'hFFFFFFFF, 32'h2008, 1);
    tick();
    chk("bad_illegal", illegal, ILL);
    chk("bad_nop", {reg_write, load, store, branch, jump, op1, op2}, 0);
    chk("bad_valid", out_valid, 1);
    drive(32'h00000013, 32'h3000, 0);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold", pc_out, 32'h2008);
    out_ready = 1'b0;
    drive(32'h00100293, 32'h40, 1);
    tick();
    chk("s1_valid", out_valid, 1);
    chk("s1_imm", imm, 1);
    drive(32'h00200293, 32'h80, 1);
    chk("s_ready_low", in_ready, 0);
    tick();
    tick();
    tick();
    chk("s_hold", {out_valid, imm, pc_out}, {1'b1, 32'd1, 32'h40});
    chk("s_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("s_ready_high", in_ready, 1);
    tick();
    chk("s2", {out_valid, imm, pc_out}, {1'b1, 32'd2, 32'h80});
    drive(32'h00300293, 32'hC0, 1);
    tick();
    chk("s3", {out_valid, imm, pc_out}, {1'b1, 32'd3, 32'hC0});
    drive(32'h00400293, 32'h100, 1);
    tick();
    chk("s4", {out_valid, imm, pc_out}, {1'b1, 32'd4, 32'h100});
    drive(32'h00000013, 32'h0, 0);
    tick();
    chk("s_end", {out_valid, imm}, {1'b0, 32'd4});
    out_ready = 1'b0;
    drive(32'h00900293, 32'h200, 1);
    tick();
    chk("f_held", {out_valid, imm}, {1'b1, 32'd9});
    flush = 1'b1;
    drive(32'h00A00293, 32'h204, 1);
    tick();
    chk("f_valid", out_valid, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(32'h00000013, 32'h0, 0);
    tick();
    chk("f_dropped", {out_valid, imm, pc_out}, {1'b0, 32'd9, 32'h200});
    drive(32'hFFF08293, 32'h300, 1);
    tick();
    chk("r_pre", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("r_mid", {out_valid, reg_write}, 0);
    chk("r_data", op2 | imm | pc_out, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
